out_port_seq_ctrl: RTL

- Sequences the video output port and the VDMA read side that feeds its FIFO.
- Per frame: requests a frame-buffer read from the VDMA read master and waits for the FIFO to prefill, then enables the internal sync generator.
- While running, re-arms a read request at every end-of-frame, rotating through NUM_BUF buffers.
- On FIFO underflow it stops the sync, flushes the FIFO, counts the error, and restarts cleanly on a frame boundary.

---
 rtl/out_port_seq_ctrl_pkg.sv | 25 ++
 rtl/out_port_seq_ctrl_req_ack_handshake.sv | 62 ++++++
 rtl/out_port_seq_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/out_port_seq_ctrl_pkg.sv
// Shared types and helpers for the output-port sequencer: FSM state encoding,
// default timing constants and the frame-buffer rotation function.
package out_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_PREFILL,
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH
  } out_seq_state_e;

  localparam int unsigned FLUSH_CYC_DEF = 8;
  localparam int unsigned ACK_TMO_DEF   = 4096;

  // Wraps modulo num; a single buffer always stays at index 0.
  function automatic logic [1:0] next_buf_idx(input logic [1:0] idx, input int unsigned num);
    logic [1:0] nxt;
    if (num <= 1 || (32'(idx) + 32'd1) >= num) nxt = 2'd0;
    else nxt = idx + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/out_port_seq_ctrl_req_ack_handshake.sv
// Frame-read request holder: keeps req_o high until an ack or ACK_TMO idle cycles,
// and latches a sticky error on timeout. set_i/clr_i come from the sequencer FSM.
module req_ack_handshake
  import out_port_pkg::*;
#(
  parameter int unsigned ACK_TMO = ACK_TMO_DEF
) (
  input  logic clock,
  input  logic rst_n,
  input  logic set_i,
  input  logic clr_i,
  input  logic ack_i,
  output logic req_o,
  output logic accept_o,
  output logic timeout_o,
  output logic timeout_err_o
);

  localparam int unsigned TW = $clog2(ACK_TMO + 1);

  logic          req_q, req_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  assign tmo_hit = req_q && !ack_i && (tmo_q == TW'(ACK_TMO - 1));

  always_comb begin
    req_d = req_q;
    tmo_d = tmo_q;
    // The error latches even when the FSM clears the request in the same cycle.
    err_d = err_q | tmo_hit;
    if (clr_i) begin
      req_d = 1'b0;
      tmo_d = '0;
    end else if (set_i) begin
      req_d = 1'b1;
      tmo_d = '0;
    end else if (req_q) begin
      if (ack_i || tmo_hit) req_d = 1'b0;
      else                  tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      req_q <= req_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end

  assign req_o         = req_q;
  assign accept_o      = req_q && ack_i;
  assign timeout_o     = tmo_hit;
  assign timeout_err_o = err_q;

endmodule

// File: rtl/out_port_seq_ctrl.sv
// Output-port sequencer: flushes the FIFO, requests a frame buffer, waits for prefill,
// then runs the sync generator, re-arming reads per frame and recovering from underflow.
module out_port_seq_ctrl
  import out_port_pkg::*;
#(
  parameter int unsigned CSIZE     = 10,
  parameter int unsigned NUM_BUF   = 3,
  parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int unsigned ACK_TMO   = ACK_TMO_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CSIZE-1:0] prefill_th_i,
  input  logic [CSIZE-1:0] fifo_count_i,
  input  logic             fifo_empty_i,
  input  logic             rd_en_i,
  input  logic             ealign_i,
  output logic             frame_req_o,
  input  logic             frame_ack_i,
  output logic [1:0]       frame_buf_idx_o,
  output logic             enable_inner_sync_o,
  output logic             fifo_flush_o,
  output logic [15:0]      underflow_cnt_o,
  output logic             timeout_err_o,
  output logic             busy_o
);

  localparam int unsigned FW = $clog2(FLUSH_CYC + 1);

  out_seq_state_e state_q, state_d;
  logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
  logic           stop_q, stop_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    uf_cnt_q, uf_cnt_d;
  logic           en_q, en_d;
  logic           flush_q, flush_d;
  logic           busy_q, busy_d;

  logic frame_req, req_accept, req_timeout, req_set, req_clr;
  logic underflow, rearm, flush_done;

  assign underflow  = rd_en_i && fifo_empty_i && (state_q == ST_RUN || state_q == ST_DRAIN);
  // A still-pending request means a late frame: keep it and do not advance again.
  assign rearm      = (state_q == ST_RUN) && start_i && ealign_i && !underflow && !frame_req;
  assign flush_done = (state_q == ST_FLUSH) && (flush_cnt_q == FW'(FLUSH_CYC - 1));

  always_ff @(posedge clock) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_FLUSH;
      ST_FLUSH:   if (flush_done) state_d = (start_i && !stop_q) ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        if (req_accept)       state_d = ST_PREFILL;
        else if (req_timeout) state_d = ST_IDLE;
      end
      ST_PREFILL: begin
        if (!start_i)                          state_d = ST_FLUSH;
        else if (fifo_count_i >= prefill_th_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (underflow)     state_d = ST_FLUSH;
        else if (!start_i) state_d = ST_DRAIN;
      end
      ST_DRAIN:   if (underflow || ealign_i) state_d = ST_FLUSH;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d        = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    flush_d     = (state_d == ST_FLUSH);
    busy_d      = (state_d != ST_IDLE);
    flush_cnt_d = (state_q == ST_FLUSH && state_d == ST_FLUSH) ? flush_cnt_q + FW'(1) : '0;
    // A flush entered from DRAIN must end in IDLE even if start came back.
    stop_d      = (state_d == ST_FLUSH) && (stop_q || state_q == ST_DRAIN);
    idx_d       = rearm ? next_buf_idx(idx_q, NUM_BUF) : idx_q;
    uf_cnt_d    = (underflow && uf_cnt_q != 16'hFFFF) ? uf_cnt_q + 16'd1 : uf_cnt_q;
    req_set     = ((state_d == ST_REQ) && (state_q != ST_REQ)) || rearm;
    req_clr     = (state_d == ST_FLUSH) || (state_d == ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
      stop_q      <= 1'b0;
      idx_q       <= 2'd0;
      uf_cnt_q    <= 16'd0;
      en_q        <= 1'b0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stop_q      <= stop_d;
      idx_q       <= idx_d;
      if (underflow) uf_cnt_q <= uf_cnt_d;
      en_q        <= en_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
    end
  end

  req_ack_handshake #(
    .ACK_TMO (ACK_TMO)
  ) u_hs (
    .clock         (clock),
    .rst_n         (rst_n),
    .set_i         (req_set),
    .clr_i         (req_clr),
    .ack_i         (frame_ack_i),
    .req_o         (frame_req),
    .accept_o      (req_accept),
    .timeout_o     (req_timeout),
    .timeout_err_o (timeout_err_o)
  );

  assign frame_req_o         = frame_req;
  assign frame_buf_idx_o     = idx_q;
  assign enable_inner_sync_o = en_q;
  assign fifo_flush_o        = flush_q;
  assign underflow_cnt_o     = uf_cnt_q;
  assign busy_o              = busy_q;

endmodule
